// File: rtl/pb_event_gen.sv
// Push-button event generator: one pulse per press, plus hold-to-repeat pulses on masked channels.
// Optional macro PB_EVENT_RELEASE_EN adds the PB_released pulse output.
module pb_event_gen #(
    parameter int          CLK_DIV          = 25000,
    parameter int          REPEAT_DELAY_MS  = 500,
    parameter int          REPEAT_PERIOD_MS = 100,
    parameter logic [3:0]  REPEAT_MASK      = 4'b0011
) (
    input  logic       Clock_25,
    input  logic       Resetn,
    input  logic [3:0] PB_pushed,
    output logic [3:0] PB_event,
    output logic [3:0] PB_held
`ifdef PB_EVENT_RELEASE_EN
    ,
    output logic [3:0] PB_released
`endif
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int CNT_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD_MS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [3:0]       prev_reg;
    logic             tick;

    // Free-running 1 ms divider shared by every channel; the tick phase is not tied to presses.
    always_ff @(posedge Clock_25 or negedge Resetn) begin
        if (!Resetn) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    assign tick = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge Clock_25 or negedge Resetn) begin
        if (!Resetn) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= PB_pushed;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             event_reg;
            logic             held_reg;
            logic             released_reg;

            // Release is tested before the tick so a repeat due in the same cycle is dropped.
            always_ff @(posedge Clock_25 or negedge Resetn) begin
                if (!Resetn) begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    event_reg    <= 1'b0;
                    held_reg     <= 1'b0;
                    released_reg <= 1'b0;
                end else begin
                    event_reg    <= 1'b0;
                    released_reg <= 1'b0;
                    case (state_reg)
                        IDLE: begin
                            if (PB_pushed[gi] && !prev_reg[gi]) begin
                                state_reg <= DELAY;
                                cnt_reg   <= '0;
                                event_reg <= 1'b1;
                                held_reg  <= 1'b1;
                            end
                        end
                        DELAY: begin
                            if (!PB_pushed[gi]) begin
                                state_reg    <= IDLE;
                                cnt_reg      <= '0;
                                held_reg     <= 1'b0;
                                released_reg <= 1'b1;
                            end else if (tick) begin
                                if (cnt_reg == DELAY_LAST) begin
                                    // Non-repeating channels park here with the counter saturated.
                                    if (REPEAT_MASK[gi]) begin
                                        state_reg <= REPEAT;
                                        cnt_reg   <= '0;
                                        event_reg <= 1'b1;
                                    end
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end
                        end
                        REPEAT: begin
                            if (!PB_pushed[gi]) begin
                                state_reg    <= IDLE;
                                cnt_reg      <= '0;
                                held_reg     <= 1'b0;
                                released_reg <= 1'b1;
                            end else if (tick) begin
                                if (cnt_reg == PERIOD_LAST) begin
                                    cnt_reg   <= '0;
                                    event_reg <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            held_reg  <= 1'b0;
                        end
                    endcase
                end
            end

            assign PB_event[gi] = event_reg;
            assign PB_held[gi]  = held_reg;
`ifdef PB_EVENT_RELEASE_EN
            assign PB_released[gi] = released_reg;
`else
            logic unused_released;
            assign unused_released = released_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pb_event_gen.sv
// Scoreboard bench for pb_event_gen: stimulus pushes expected pulses (edge index, value); a monitor pops them.
module tb_pb_event_gen;

    localparam int         CLK_DIV = 4;
    localparam int         DLY     = 3;
    localparam int         PER     = 2;
    localparam logic [3:0] MASK    = 4'b0001;

    logic       Clock_25  = 1'b0;
    logic       Resetn    = 1'b0;
    logic [3:0] PB_pushed = 4'b0;
    logic [3:0] PB_event;
    logic [3:0] PB_held;
`ifdef PB_EVENT_RELEASE_EN
    logic [3:0] PB_released;
`endif

    pb_event_gen #(
        .CLK_DIV         (CLK_DIV),
        .REPEAT_DELAY_MS (DLY),
        .REPEAT_PERIOD_MS(PER),
        .REPEAT_MASK     (MASK)
    ) dut (
        .Clock_25   (Clock_25),
        .Resetn     (Resetn),
        .PB_pushed  (PB_pushed),
        .PB_event   (PB_event),
`ifdef PB_EVENT_RELEASE_EN
        .PB_released(PB_released),
`endif
        .PB_held    (PB_held)
    );

    always #5 Clock_25 = ~Clock_25;

    // Index of the last rising edge seen since reset release; edge p ticks when p % CLK_DIV == 0.
    int cyc;
    always @(posedge Clock_25 or negedge Resetn) begin
        if (!Resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [3:0] val;
    } exp_t;

    exp_t ev_q[$];
    exp_t rel_q[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(negedge Clock_25);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (ev_q.size() != 0 || rel_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d event / %0d release pulses still pending, required 0",
                     name, ev_q.size(), rel_q.size());
        end
    endtask

    // Edge of the first repeat: DLY ticks after the press edge k.
    function automatic int first_rep(input int k);
        return ((k / CLK_DIV) + 1) * CLK_DIV + (DLY - 1) * CLK_DIV;
    endfunction

    always @(negedge Clock_25) begin
        exp_t e;
        if (Resetn) begin
            while (ev_q.size() > 0 && ev_q[0].at < cyc) begin
                e = ev_q.pop_front();
                checks++;
                errors++;
                $display("FAIL event_missed: got none, required PB_event=%b at cycle %0d", e.val, e.at);
            end
            if (PB_event != 4'b0) begin
                checks++;
                if (ev_q.size() == 0 || ev_q[0].at != cyc) begin
                    errors++;
                    $display("FAIL event_unexpected: got PB_event=%b at cycle %0d, required none", PB_event, cyc);
                end else begin
                    e = ev_q.pop_front();
                    if (PB_event !== e.val) begin
                        errors++;
                        $display("FAIL event_value: got PB_event=%b, required %b at cycle %0d", PB_event, e.val, cyc);
                    end else begin
                        $display("event  cycle %0d PB_event=%b", cyc, PB_event);
                    end
                end
            end
`ifdef PB_EVENT_RELEASE_EN
            while (rel_q.size() > 0 && rel_q[0].at < cyc) begin
                e = rel_q.pop_front();
                checks++;
                errors++;
                $display("FAIL release_missed: got none, required PB_released=%b at cycle %0d", e.val, e.at);
            end
            if (PB_released != 4'b0) begin
                checks++;
                if (rel_q.size() == 0 || rel_q[0].at != cyc) begin
                    errors++;
                    $display("FAIL release_unexpected: got PB_released=%b at cycle %0d, required none", PB_released, cyc);
                end else begin
                    e = rel_q.pop_front();
                    if (PB_released !== e.val) begin
                        errors++;
                        $display("FAIL release_value: got PB_released=%b, required %b at cycle %0d", PB_released, e.val, cyc);
                    end else begin
                        $display("relse  cycle %0d PB_released=%b", cyc, PB_released);
                    end
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int r;

        // Reset held, then 20 idle cycles after release.
        repeat (5) begin
            tick_wait(1);
            check("reset_event", PB_event, 4'b0000);
            check("reset_held", PB_held, 4'b0000);
        end
        Resetn = 1'b1;
        repeat (20) begin
            tick_wait(1);
            check("idle_event", PB_event, 4'b0000);
            check("idle_held", PB_held, 4'b0000);
        end

        // Short press on channel 0 for 5 cycles: one pulse, no repeat.
        PB_pushed[0] = 1'b1;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b0001});
        repeat (5) begin
            tick_wait(1);
            check("short_held", PB_held, 4'b0001);
        end
        PB_pushed[0] = 1'b0;
        tick_wait(1);
        check("short_release_held", PB_held, 4'b0000);
        tick_wait(15);
        check_drained("short_drained");

        // Long hold on channel 0 for 40 cycles: press, first repeat, then every PER*CLK_DIV.
        PB_pushed[0] = 1'b1;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b0001});
        r = first_rep(k);
        while (r <= k + 39) begin
            ev_q.push_back('{at: r, val: 4'b0001});
            r += PER * CLK_DIV;
        end
        tick_wait(40);
        check("long_held", PB_held, 4'b0001);
        PB_pushed[0] = 1'b0;
        tick_wait(1);
        check("long_release_held", PB_held, 4'b0000);
        tick_wait(20);
        check_drained("long_drained");

        // Channel 1 has repeat disabled: one pulse for a 40-cycle hold.
        PB_pushed[1] = 1'b1;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b0010});
        tick_wait(40);
        check("mask_held", PB_held, 4'b0010);
        PB_pushed[1] = 1'b0;
        tick_wait(1);
        check("mask_release_held", PB_held, 4'b0000);
        tick_wait(10);
        check_drained("mask_drained");

        // Channels 0 and 3 together; channel 0 released on the edge its first repeat falls due.
        PB_pushed = 4'b1001;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b1001});
        r = first_rep(k);
        tick_wait(r - 1 - cyc);
        PB_pushed[0] = 1'b0;
        tick_wait(1);
        check("simul_held", PB_held, 4'b1000);
        tick_wait(20);
        PB_pushed[3] = 1'b0;
        tick_wait(1);
        check("simul_release_held", PB_held, 4'b0000);
        tick_wait(5);
        check_drained("simul_drained");

`ifdef PB_EVENT_RELEASE_EN
        // Press and release channel 2: release pulse on the edge that samples the fall.
        PB_pushed[2] = 1'b1;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b0100});
        tick_wait(3);
        PB_pushed[2] = 1'b0;
        rel_q.push_back('{at: cyc + 1, val: 4'b0100});
        tick_wait(1);
        check("rel_held", PB_held, 4'b0000);
        tick_wait(5);
        check_drained("rel_drained");
`endif

        // Reset asserted between edges mid-hold clears outputs at once; the held press re-fires after.
        PB_pushed[0] = 1'b1;
        k = cyc + 1;
        ev_q.push_back('{at: k, val: 4'b0001});
        tick_wait(3);
        check("prereset_held", PB_held, 4'b0001);
        @(posedge Clock_25);
        #2;
        Resetn = 1'b0;
        #1;
        check("async_reset_held", PB_held, 4'b0000);
        check("async_reset_event", PB_event, 4'b0000);
`ifdef PB_EVENT_RELEASE_EN
        check("async_reset_released", PB_released, 4'b0000);
`endif
        tick_wait(2);
        Resetn = 1'b1;
        ev_q.push_back('{at: 1, val: 4'b0001});
        tick_wait(1);
        check("held_thru_reset_held", PB_held, 4'b0001);
        tick_wait(3);
        PB_pushed[0] = 1'b0;
        tick_wait(1);
        check("held_thru_reset_release", PB_held, 4'b0000);
        tick_wait(5);
        check_drained("final_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
